// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw bouncing input, accepts a new level only
// after it has been seen unchanged for STABLE_CYCLES consecutive samples, and
// produces one-cycle rise/fall strobes plus a saturating count of aborted
// transitions. There is no valid/ready handshake here: every output is a plain
// registered level or a single-cycle strobe.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       noisy_in,
    input  logic       glitch_clr,
    output logic       clean_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] glitch_count,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    // Encoding chosen so that bit 1 equals the accepted level and bit 0 means
    // "qualifying a candidate"; outputs are still kept in their own registers.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   clean_q;
    logic                   busy_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             glitch_q;
    logic [7:0]             glitch_d;
    logic                   s;
    logic                   abort;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the metastability-hardening chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
        end
    end

    // Qualification FSM with registered level, busy flag and edge strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            busy_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE_LOW: begin
                    if (s) begin
                        state_q <= PEND_HIGH;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                PEND_HIGH: begin
                    // A reversal is checked first so that it wins even on the
                    // final qualifying sample.
                    if (!s) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        clean_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state_q <= PEND_LOW;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                PEND_LOW: begin
                    if (s) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        clean_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= STABLE_LOW;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    clean_q <= 1'b0;
                end
            endcase
        end
    end

    // An abort is a reversal of s while a candidate is being qualified.
    assign abort = ((state_q == PEND_HIGH) && !s) || ((state_q == PEND_LOW) && s);

    // Next glitch count: clear beats increment, increment saturates at 255.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = 8'd0;
        end else if (abort && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    // Glitch counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q <= 8'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign clean_out    = clean_q;
    assign busy         = busy_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign glitch_count = glitch_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer: two instances (default parameters and
// SYNC_STAGES=3/STABLE_CYCLES=2) are compared every cycle against a run-length
// reference model, plus directed latency/boundary scenarios and random bursts.
module tb_input_debouncer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A (defaults) ----------------
    logic       noisy_a = 1'b0;
    logic       clr_a   = 1'b0;
    logic       clean_a, rise_a, fall_a, busy_a;
    logic [7:0] glitch_a;
    logic [1:0] dbg_a;

    input_debouncer dut_a (
        .clk          (clk),
        .reset        (reset),
        .noisy_in     (noisy_a),
        .glitch_clr   (clr_a),
        .clean_out    (clean_a),
        .rise_pulse   (rise_a),
        .fall_pulse   (fall_a),
        .glitch_count (glitch_a),
        .busy         (busy_a),
        .dbg_state    (dbg_a)
    );

    // ---------------- DUT B (parameter sweep) ----------------
    logic       noisy_b = 1'b0;
    logic       clr_b   = 1'b0;
    logic       clean_b, rise_b, fall_b, busy_b;
    logic [7:0] glitch_b;
    logic [1:0] dbg_b;

    input_debouncer #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (2)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .noisy_in     (noisy_b),
        .glitch_clr   (clr_b),
        .clean_out    (clean_b),
        .rise_pulse   (rise_b),
        .fall_pulse   (fall_b),
        .glitch_count (glitch_b),
        .busy         (busy_b),
        .dbg_state    (dbg_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Abstract view: an accepted level plus the length of the current run of
    // synchronized samples that disagree with it. A run reaching the stable
    // length flips the level; a run broken early is a glitch.
    int         m_lvl[2];
    int         m_run[2];
    int         m_glitch[2];
    bit         m_rise[2];
    bit         m_fall[2];
    logic [7:0] m_pipe[2];

    function automatic int sync_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int stab_of(input int i);
        return (i == 0) ? 16 : 2;
    endfunction

    task automatic model_clear(input int i);
        m_lvl[i]    = 0;
        m_run[i]    = 0;
        m_glitch[i] = 0;
        m_rise[i]   = 1'b0;
        m_fall[i]   = 1'b0;
        m_pipe[i]   = 8'd0;
    endtask

    task automatic model_step(input int i, input logic nin, input logic clr);
        int  s;
        bit  broke;
        s         = int'(m_pipe[i][sync_of(i)-1]);
        broke     = 1'b0;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (s != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == stab_of(i)) begin
                m_lvl[i] = s;
                m_run[i] = 0;
                if (s == 1) m_rise[i] = 1'b1;
                else        m_fall[i] = 1'b1;
            end
        end else begin
            broke    = (m_run[i] > 0);
            m_run[i] = 0;
        end
        if (clr)                          m_glitch[i] = 0;
        else if (broke && m_glitch[i] < 255) m_glitch[i]++;
        m_pipe[i] = {m_pipe[i][6:0], nin};
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear(0);
            model_clear(1);
        end else begin
            model_step(0, noisy_a, clr_a);
            model_step(1, noisy_b, clr_b);
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check_eq("a_clean",  32'(clean_a),  32'(m_lvl[0]));
            check_eq("a_busy",   32'(busy_a),   32'(m_run[0] > 0));
            check_eq("a_rise",   32'(rise_a),   32'(m_rise[0]));
            check_eq("a_fall",   32'(fall_a),   32'(m_fall[0]));
            check_eq("a_glitch", 32'(glitch_a), 32'(m_glitch[0]));
            check_eq("b_clean",  32'(clean_b),  32'(m_lvl[1]));
            check_eq("b_busy",   32'(busy_b),   32'(m_run[1] > 0));
            check_eq("b_rise",   32'(rise_b),   32'(m_rise[1]));
            check_eq("b_fall",   32'(fall_b),   32'(m_fall[1]));
            check_eq("b_glitch", 32'(glitch_b), 32'(m_glitch[1]));
        end
    end

    // ---------------- edge counter and pulse recorders ----------------
    int edge_n = 0;
    int rise_cnt_a = 0, fall_cnt_a = 0, last_rise_a = -1, last_fall_a = -1;

    always @(posedge clk) begin
        edge_n++;
        #1;
        if (rise_a) begin rise_cnt_a++; last_rise_a = edge_n; end
        if (fall_a) begin fall_cnt_a++; last_fall_a = edge_n; end
    end

    // ---------------- driver helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to_edge(input int tgt);
        int guard = 0;
        while (edge_n < tgt && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n < tgt) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_to_edge: got=%0d expected=%0d", edge_n, tgt);
        end
    endtask

    int e0;
    int rb, fb;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset sequence
        reset = 1'b0;
        idle(3);
        chk_en = 1'b1;
        check_eq("rst_clean", 32'(clean_a), 0);
        check_eq("rst_rise", 32'(rise_a), 0);
        check_eq("rst_fall", 32'(fall_a), 0);
        check_eq("rst_glitch", 32'(glitch_a), 0);
        check_eq("rst_busy", 32'(busy_a), 0);
        reset = 1'b1;
        idle(20);

        // Clean rise with default parameters
        noisy_a = 1'b1;
        e0 = edge_n + 1;
        rb = rise_cnt_a;
        wait_to_edge(e0 + 16);
        check_eq("rise_not_early", 32'(clean_a), 0);
        wait_to_edge(e0 + 17);
        check_eq("rise_clean", 32'(clean_a), 1);
        check_eq("rise_pulse", 32'(rise_a), 1);
        wait_to_edge(e0 + 18);
        check_eq("rise_pulse_drop", 32'(rise_a), 0);
        check_eq("rise_glitch", 32'(glitch_a), 0);
        check_eq("rise_count", 32'(rise_cnt_a - rb), 1);
        idle(5);

        // Low for exactly 15 cycles: aborted on the final qualifying edge
        fb = fall_cnt_a;
        noisy_a = 1'b0;
        e0 = edge_n + 1;
        idle(15);
        noisy_a = 1'b1;
        wait_to_edge(e0 + 16);
        check_eq("bnd_busy", 32'(busy_a), 1);
        wait_to_edge(e0 + 17);
        check_eq("bnd_clean", 32'(clean_a), 1);
        check_eq("bnd_glitch", 32'(glitch_a), 1);
        check_eq("bnd_no_fall", 32'(fall_cnt_a - fb), 0);
        idle(5);

        // Sustained low: accepted fall
        noisy_a = 1'b0;
        e0 = edge_n + 1;
        wait_to_edge(e0 + 17);
        check_eq("fall_pulse", 32'(fall_a), 1);
        check_eq("fall_clean", 32'(clean_a), 0);
        check_eq("fall_edge", 32'(last_fall_a), 32'(e0 + 17));
        wait_to_edge(e0 + 18);
        check_eq("fall_pulse_drop", 32'(fall_a), 0);
        idle(5);

        // Bounce: high 5, low 3, then high and hold
        rb = rise_cnt_a;
        noisy_a = 1'b1;
        idle(5);
        noisy_a = 1'b0;
        idle(3);
        noisy_a = 1'b1;
        e0 = edge_n + 1;
        wait_to_edge(e0 + 17);
        check_eq("bounce_clean", 32'(clean_a), 1);
        check_eq("bounce_rise_edge", 32'(last_rise_a), 32'(e0 + 17));
        idle(5);
        check_eq("bounce_rise_count", 32'(rise_cnt_a - rb), 1);
        check_eq("bounce_glitch", 32'(glitch_a), 2);

        // Return low, then 300 short glitches to saturate the count
        noisy_a = 1'b0;
        idle(25);
        for (int k = 0; k < 300; k++) begin
            noisy_a = 1'b1;
            idle(3);
            noisy_a = 1'b0;
            idle(3);
        end
        idle(6);
        check_eq("sat_glitch", 32'(glitch_a), 255);
        check_eq("sat_clean", 32'(clean_a), 0);

        // Clear asserted on the same edge as a glitch abort
        noisy_a = 1'b1;
        e0 = edge_n + 1;
        idle(3);
        noisy_a = 1'b0;
        wait_to_edge(e0 + 4);
        check_eq("clr_pre_busy", 32'(busy_a), 1);
        check_eq("clr_pre_glitch", 32'(glitch_a), 255);
        clr_a = 1'b1;
        wait_to_edge(e0 + 5);
        clr_a = 1'b0;
        check_eq("clr_wins", 32'(glitch_a), 0);
        check_eq("clr_busy", 32'(busy_a), 0);
        idle(5);

        // Reset while qualifying a rise (cnt=10)
        noisy_a = 1'b1;
        e0 = edge_n + 1;
        wait_to_edge(e0 + 11);
        check_eq("midq_busy", 32'(busy_a), 1);
        reset = 1'b0;
        #1;
        check_eq("midq_rst_busy", 32'(busy_a), 0);
        check_eq("midq_rst_clean", 32'(clean_a), 0);
        check_eq("midq_rst_rise", 32'(rise_a), 0);
        check_eq("midq_rst_fall", 32'(fall_a), 0);
        check_eq("midq_rst_glitch", 32'(glitch_a), 0);
        idle(2);
        reset = 1'b1;
        e0 = edge_n + 1;
        rb = rise_cnt_a;
        wait_to_edge(e0 + 17);
        check_eq("rel_rise", 32'(rise_a), 1);
        check_eq("rel_clean", 32'(clean_a), 1);
        idle(3);
        check_eq("rel_rise_count", 32'(rise_cnt_a - rb), 1);
        check_eq("rel_glitch", 32'(glitch_a), 0);

        // Parameter sweep instance: rise at E0+4, one-cycle glitch counted once
        noisy_b = 1'b1;
        e0 = edge_n + 1;
        wait_to_edge(e0 + 3);
        check_eq("b_not_early", 32'(clean_b), 0);
        wait_to_edge(e0 + 4);
        check_eq("b_rise_clean", 32'(clean_b), 1);
        check_eq("b_rise_pulse", 32'(rise_b), 1);
        noisy_b = 1'b0;
        idle(10);
        check_eq("b_fall_clean", 32'(clean_b), 0);
        noisy_b = 1'b1;
        idle(1);
        noisy_b = 1'b0;
        idle(8);
        check_eq("b_glitch_one", 32'(glitch_b), 1);
        check_eq("b_glitch_clean", 32'(clean_b), 0);

        // Random bursts on both instances, checked cycle by cycle
        for (int k = 0; k < 150; k++) begin
            int len;
            noisy_a = 1'($urandom_range(0, 1));
            noisy_b = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            repeat (len) begin
                clr_a = ($urandom_range(0, 31) == 0);
                clr_b = ($urandom_range(0, 31) == 0);
                @(negedge clk);
            end
        end
        clr_a = 1'b0;
        clr_b = 1'b0;
        idle(25);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
